vmul_result_collector: RTL and testbench

Downstream stage of the SEW-configurable vector multiplier. Each cycle the multiplier can deliver one 64-bit beat of full-width products from one 32-bit operand word. This block takes those beats and keeps the low or high SEW bits of each product. It packs the kept elements into a VLEN-bit destination-register image, zeroes tail elements at and beyond vl, and presents the finished image to writeback over a valid/ready handshake.

---
 rtl/vmul_pkg.sv | 40 ++++
 rtl/vmul_beat_extract.sv | 62 ++++++
 rtl/vmul_result_collector.sv | 151 +++++++++++++++
 tb/tb_vmul_result_collector.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vmul_pkg.sv
// Shared types and helpers for the vector-multiply result collector.
package vmul_pkg;

  typedef enum logic [1:0] {
    SEW8    = 2'b00,
    SEW16   = 2'b01,
    SEW32   = 2'b10,
    SEW_ILL = 2'b11
  } sew_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    OUTPUT  = 2'b10
  } state_e;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BEAT_W = 64;

  // Elements packed into one 32-bit result word (one beat) for a given SEW.
  function automatic logic [2:0] epb_of(input sew_e s);
    case (s)
      SEW8:    epb_of = 3'd4;
      SEW16:   epb_of = 3'd2;
      SEW32:   epb_of = 3'd1;
      default: epb_of = 3'd0;
    endcase
  endfunction

  // log2 of the elements-per-beat count; turns beat index into element index.
  function automatic logic [1:0] epb_log2(input sew_e s);
    case (s)
      SEW8:    epb_log2 = 2'd2;
      SEW16:   epb_log2 = 2'd1;
      SEW32:   epb_log2 = 2'd0;
      default: epb_log2 = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vmul_beat_extract.sv
// Turns one 64-bit product beat into one packed 32-bit result word:
// picks the low or high SEW bits of each double-width lane and zeroes
// elements whose index falls at or beyond vl.
module vmul_beat_extract
  import vmul_pkg::*;
#(
  parameter int VLW = 7
) (
  input  logic [BEAT_W-1:0] i_product,
  input  sew_e              i_sew,
  input  logic              i_high,
  input  logic [VLW-1:0]    i_base,
  input  logic [VLW-1:0]    i_vl,
  output logic [WORD_W-1:0] o_word
);

  // Lane selection and tail masking for the current element width
  always_comb begin
    o_word = 32'h0000_0000;
    case (i_sew)
      SEW8: begin
        for (int j = 0; j < 4; j++) begin
          if ((i_base + VLW'(j)) < i_vl) begin
            if (i_high) begin
              o_word[8*j +: 8] = i_product[16*j+8 +: 8];
            end else begin
              o_word[8*j +: 8] = i_product[16*j +: 8];
            end
          end else begin
            o_word[8*j +: 8] = 8'h00;
          end
        end
      end
      SEW16: begin
        for (int j = 0; j < 2; j++) begin
          if ((i_base + VLW'(j)) < i_vl) begin
            if (i_high) begin
              o_word[16*j +: 16] = i_product[32*j+16 +: 16];
            end else begin
              o_word[16*j +: 16] = i_product[32*j +: 16];
            end
          end else begin
            o_word[16*j +: 16] = 16'h0000;
          end
        end
      end
      SEW32: begin
        if (i_base < i_vl) begin
          if (i_high) begin
            o_word = i_product[63:32];
          end else begin
            o_word = i_product[31:0];
          end
        end else begin
          o_word = 32'h0000_0000;
        end
      end
      default: o_word = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/vmul_result_collector.sv
// Collects SEW-configurable multiplier product beats into a VLEN-bit
// destination image and hands the finished image to writeback.
module vmul_result_collector
  import vmul_pkg::*;
#(
  parameter int VLEN = 512,
  parameter int VLW  = $clog2(VLEN/8) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_sew,
  input  logic              cmd_high,
  input  logic [VLW-1:0]    cmd_vl,
  input  logic              in_valid,
  input  logic [BEAT_W-1:0] product_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VLEN-1:0]   vd_data,
  output logic              err_sew,
  output logic              busy
);

  localparam int NWORDS = VLEN / 32;
  localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  state_e                         r_state;
  sew_e                           r_sew;
  logic                           r_high;
  logic [VLW-1:0]                 r_vl;
  logic [VLW-1:0]                 r_nb;
  logic [VLW-1:0]                 r_beat;
  logic [NWORDS-1:0][WORD_W-1:0]  r_buf;
  logic                           r_cmd_ready;
  logic                           r_out_valid;
  logic                           r_busy;
  logic                           r_err_sew;

  sew_e                           w_cmd_sew;
  logic [VLW-1:0]                 w_nb;
  logic [VLW-1:0]                 w_base;
  logic [IW-1:0]                  w_beat_idx;
  logic                           w_beat_in_range;
  logic                           w_last_beat;
  logic [WORD_W-1:0]              w_word;

  // Beat count for the incoming command and element base of the current beat
  always_comb begin
    w_cmd_sew       = sew_e'(cmd_sew);
    w_nb            = (cmd_vl + VLW'(epb_of(w_cmd_sew)) - VLW'(1'b1)) >> epb_log2(w_cmd_sew);
    w_base          = r_beat << epb_log2(r_sew);
    w_beat_idx      = r_beat[IW-1:0];
    w_beat_in_range = (r_beat < VLW'(NWORDS));
    w_last_beat     = (r_beat == (r_nb - VLW'(1'b1)));
  end

  vmul_beat_extract #(
    .VLW (VLW)
  ) u_extract (
    .i_product (product_in),
    .i_sew     (r_sew),
    .i_high    (r_high),
    .i_base    (w_base),
    .i_vl      (r_vl),
    .o_word    (w_word)
  );

  // Command capture, beat collection and writeback handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_sew       <= SEW8;
      r_high      <= 1'b0;
      r_vl        <= '0;
      r_nb        <= '0;
      r_beat      <= '0;
      r_buf       <= '0;
      r_cmd_ready <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err_sew   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_sew       <= w_cmd_sew;
            r_high      <= cmd_high;
            r_vl        <= cmd_vl;
            r_nb        <= w_nb;
            r_beat      <= '0;
            r_buf       <= '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (w_cmd_sew == SEW_ILL) begin
              // Illegal width: flag it and hand back an all-zero image
              r_err_sew   <= 1'b1;
              r_state     <= OUTPUT;
              r_out_valid <= 1'b1;
            end else begin
              r_err_sew <= 1'b0;
              if (cmd_vl == '0) begin
                r_state     <= OUTPUT;
                r_out_valid <= 1'b1;
              end else begin
                r_state     <= COLLECT;
                r_out_valid <= 1'b0;
              end
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        COLLECT: begin
          if (in_valid) begin
            // Guard against vl beyond the register size wrapping into low words
            if (w_beat_in_range) begin
              r_buf[w_beat_idx] <= w_word;
            end
            r_beat <= r_beat + VLW'(1'b1);
            if (w_last_beat) begin
              r_state     <= OUTPUT;
              r_out_valid <= 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign err_sew   = r_err_sew;
  assign vd_data   = r_buf;

endmodule

// File: tb/tb_vmul_result_collector.sv
// Randomized self-checking bench for vmul_result_collector with an
// element-level reference model.
module tb_vmul_result_collector;

  localparam int VLEN = 512;
  localparam int VLW  = $clog2(VLEN/8) + 1;

  logic            clk;
  logic            reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_sew;
  logic            cmd_high;
  logic [VLW-1:0]  cmd_vl;
  logic            in_valid;
  logic [63:0]     product_in;
  logic            out_valid;
  logic            out_ready;
  logic [VLEN-1:0] vd_data;
  logic            err_sew;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] g_beats [16];

  vmul_result_collector #(.VLEN(VLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_sew    (cmd_sew),
    .cmd_high   (cmd_high),
    .cmd_vl     (cmd_vl),
    .in_valid   (in_valid),
    .product_in (product_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .vd_data    (vd_data),
    .err_sew    (err_sew),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Element k is product lane (k mod EPB) of beat (k div EPB); keep low or high half.
  function automatic logic [VLEN-1:0] model_image(input int sew, input bit hi, input int vl);
    logic [VLEN-1:0] img;
    logic [VLEN-1:0] t;
    logic [63:0]     lane;
    logic [63:0]     mask;
    logic [63:0]     val;
    int sw;
    int epb;
    img = '0;
    if (sew == 3) return img;
    sw   = 8 << sew;
    epb  = 32 / sw;
    mask = (64'd1 << sw) - 64'd1;
    for (int k = 0; k < vl; k++) begin
      lane = g_beats[k / epb] >> ((k % epb) * 2 * sw);
      val  = hi ? ((lane >> sw) & mask) : (lane & mask);
      t = '0;
      t[63:0] = val;
      img = img | (t << (k * sw));
    end
    return img;
  endfunction

  task automatic fill_random_beats();
    for (int i = 0; i < 16; i++) g_beats[i] = {$urandom, $urandom};
  endtask

  task automatic run_op(input int sew, input bit hi, input int vl, input int hold);
    logic [VLEN-1:0] exp;
    int sw;
    int epb;
    int nb;
    exp = model_image(sew, hi, vl);
    if (sew == 3) begin
      nb = 0;
    end else begin
      sw  = 8 << sew;
      epb = 32 / sw;
      nb  = (vl + epb - 1) / epb;
    end
    @(negedge clk);
    check_val("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_sew   = sew[1:0];
    cmd_high  = hi;
    cmd_vl    = vl[VLW-1:0];
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_sew   = 2'($urandom);
    cmd_vl    = VLW'($urandom);
    check_val("busy_accept", busy, 1'b1);
    check_val("cmd_ready_busy", cmd_ready, 1'b0);
    check_val("vd_cleared", vd_data, '0);
    if (nb == 0) begin
      check_val("ov_direct", out_valid, 1'b1);
    end else begin
      check_val("ov_early", out_valid, 1'b0);
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid   = 1'b0;
          product_in = {$urandom, $urandom};
          @(negedge clk);
          check_val("ov_gap", out_valid, 1'b0);
        end
        in_valid   = 1'b1;
        product_in = g_beats[b];
        @(negedge clk);
        in_valid = 1'b0;
        check_val("ov_beat", out_valid, (b == nb - 1) ? 1'b1 : 1'b0);
      end
    end
    for (int h = 0; h < hold; h++) begin
      out_ready  = 1'b0;
      in_valid   = 1'($urandom_range(0, 1));
      product_in = {$urandom, $urandom};
      @(negedge clk);
      check_val("ov_hold", out_valid, 1'b1);
      check_val("vd_hold", vd_data, exp);
    end
    in_valid = 1'b0;
    check_val("vd_image", vd_data, exp);
    check_val("err_sew", err_sew, (sew == 3) ? 1'b1 : 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val("ov_after", out_valid, 1'b0);
    check_val("cmd_ready_after", cmd_ready, 1'b1);
    check_val("busy_after", busy, 1'b0);
    check_val("vd_after", vd_data, exp);
  endtask

  initial begin
    int sew;
    int vmax;
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_sew    = 2'b00;
    cmd_high   = 1'b0;
    cmd_vl     = '0;
    in_valid   = 1'b0;
    product_in = 64'h0;
    out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_cmd_ready", cmd_ready, 1'b1);
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_err", err_sew, 1'b0);
    check_val("rst_vd", vd_data, '0);

    // SEW=8 low, vl=5, two beats
    g_beats[0] = 64'h0004_0003_0002_0001;
    g_beats[1] = 64'h0008_0007_0006_0005;
    run_op(0, 1'b0, 5, 1);
    check_val("plan_sew8", vd_data, 512'h05_0403_0201);

    // SEW=16 high, vl=2, held three cycles without out_ready
    g_beats[0] = 64'h9ABC_DEF0_1234_5678;
    run_op(1, 1'b1, 2, 3);
    check_val("plan_sew16", vd_data, 512'h9ABC_1234);

    // SEW=32 high, vl=1
    g_beats[0] = 64'hFFFF_FFFF_8000_0000;
    run_op(2, 1'b1, 1, 0);
    check_val("plan_sew32", vd_data, 512'hFFFF_FFFF);

    // Beats while IDLE are ignored
    repeat (3) begin
      in_valid   = 1'b1;
      product_in = {$urandom, $urandom};
      @(negedge clk);
      check_val("idle_ignore", vd_data, 512'hFFFF_FFFF);
    end
    in_valid = 1'b0;

    // vl=0, then illegal SEW, then a legal command clearing the error flag
    run_op(0, 1'b0, 0, 1);
    check_val("vl0_zero", vd_data, '0);
    run_op(3, 1'b0, 5, 1);
    check_val("ill_zero", vd_data, '0);
    fill_random_beats();
    run_op(2, 1'b0, 16, 0);

    // Reset after one of four beats, with competing cmd_valid and in_valid
    fill_random_beats();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_sew   = 2'b00;
    cmd_high  = 1'b0;
    cmd_vl    = VLW'(16);
    @(negedge clk);
    cmd_valid  = 1'b0;
    in_valid   = 1'b1;
    product_in = g_beats[0];
    @(negedge clk);
    in_valid = 1'b0;
    check_val("mid_ov", out_valid, 1'b0);
    reset      = 1'b1;
    in_valid   = 1'b1;
    cmd_valid  = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    in_valid  = 1'b0;
    cmd_valid = 1'b0;
    check_val("mrst_ov", out_valid, 1'b0);
    check_val("mrst_vd", vd_data, '0);
    check_val("mrst_cmd_ready", cmd_ready, 1'b1);
    check_val("mrst_busy", busy, 1'b0);
    fill_random_beats();
    run_op(0, 1'b0, 4, 1);

    // Randomized commands across all widths including illegal
    for (int it = 0; it < 40; it++) begin
      sew  = $urandom_range(0, 3);
      vmax = (sew == 3) ? 8 : VLEN / (8 << sew);
      fill_random_beats();
      run_op(sew, 1'($urandom_range(0, 1)), $urandom_range(0, vmax), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
